// File: rtl/ct_l2c_spsram_pkg.sv
// Shared widths and FSM encoding for the L2 cache single-port SRAM access controller.
package ct_l2c_spsram_pkg;

   localparam int ADDR_WIDTH = 9;
   localparam int DATA_WIDTH = 96;
   localparam int ENTRIES    = 512;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/ct_l2c_spsram_rr_arb.sv
// Two-way round-robin arbiter (req[0]=read, req[1]=write); en=0 suppresses all grants.
module ct_l2c_spsram_rr_arb
   import ct_l2c_spsram_pkg::*;
(
   input  logic       forever_cpuclk,
   input  logic       cpurst,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic wr_first;

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (req == 2'b11) begin
            gnt = wr_first ? 2'b10 : 2'b01;
         end else begin
            gnt = req;
         end
      end
   end

   // Priority flips toward whichever side was not granted last; reset favours the read.
   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         wr_first <= 1'b0;
      end else if (gnt[0]) begin
         wr_first <= 1'b1;
      end else if (gnt[1]) begin
         wr_first <= 1'b0;
      end
   end

endmodule

// File: rtl/ct_l2c_spsram_ctrl_512x96.sv
// Access controller for one ct_spsram_512x96: round-robin read/write arbitration, registered SRAM inputs.
// Define CT_L2C_SPSRAM_INIT_EN to zero-fill the whole array after reset before any request is granted.
module ct_l2c_spsram_ctrl_512x96 #(
   parameter int ADDR_WIDTH = ct_l2c_spsram_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = ct_l2c_spsram_pkg::DATA_WIDTH
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst,
   input  logic                  rd_req,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_gnt,
   output logic                  rd_data_vld,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  wr_req,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [DATA_WIDTH-1:0] wr_bmask,
   output logic                  wr_gnt,
   output logic                  init_busy,
   output logic [ADDR_WIDTH-1:0] sram_a,
   output logic                  sram_cen,
   output logic                  sram_gwen,
   output logic [DATA_WIDTH-1:0] sram_wen,
   output logic [DATA_WIDTH-1:0] sram_d,
   input  logic [DATA_WIDTH-1:0] sram_q
);
   import ct_l2c_spsram_pkg::*;

   state_t                state;
   logic [ADDR_WIDTH-1:0] init_cnt;
   logic [1:0]            gnt;
   logic [1:0]            rd_vld_q;

`ifdef CT_L2C_SPSRAM_INIT_EN
   state_t state_nxt;

   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         state    <= INIT;
         init_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == INIT) begin
            init_cnt <= init_cnt + 1'b1;
         end
      end
   end

   // The cycle that issues the last entry hands over to RUN.
   always_comb begin
      state_nxt = state;
      if ((state == INIT) && (init_cnt == ADDR_WIDTH'(ENTRIES - 1))) begin
         state_nxt = RUN;
      end
   end

   assign init_busy = (state == INIT);
`else
   assign state     = RUN;
   assign init_cnt  = '0;
   assign init_busy = 1'b0;
`endif

   ct_l2c_spsram_rr_arb u_arb (
      .forever_cpuclk (forever_cpuclk),
      .cpurst         (cpurst),
      .en             ((state == RUN) && !cpurst),
      .req            ({wr_req, rd_req}),
      .gnt            (gnt)
   );

   assign rd_gnt = gnt[0];
   assign wr_gnt = gnt[1];

   // Every SRAM input is registered; the sweep owns the port while INIT is active.
   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         sram_a    <= '0;
         sram_cen  <= 1'b1;
         sram_gwen <= 1'b1;
         sram_wen  <= '1;
         sram_d    <= '0;
      end else if (init_busy) begin
         sram_a    <= init_cnt;
         sram_cen  <= 1'b0;
         sram_gwen <= 1'b0;
         sram_wen  <= '0;
         sram_d    <= '0;
      end else if (gnt[0]) begin
         sram_a    <= rd_addr;
         sram_cen  <= 1'b0;
         sram_gwen <= 1'b1;
         sram_wen  <= '1;
      end else if (gnt[1]) begin
         sram_a    <= wr_addr;
         sram_cen  <= 1'b0;
         sram_gwen <= 1'b0;
         sram_wen  <= ~wr_bmask;
         sram_d    <= wr_data;
      end else begin
         sram_cen  <= 1'b1;
         sram_gwen <= 1'b1;
         sram_wen  <= '1;
      end
   end

   // Two-stage valid pipe: grant cycle, SRAM capture cycle, then Q is presented.
   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         rd_vld_q <= 2'b00;
      end else begin
         rd_vld_q <= {rd_vld_q[0], gnt[0]};
      end
   end

   assign rd_data_vld = rd_vld_q[1] && !cpurst;
   assign rd_data     = sram_q;

endmodule

// File: doc/ct_l2c_spsram_ctrl_512x96.md
# ct_l2c_spsram_ctrl_512x96

Access controller for one ct_spsram_512x96 array in the L2 cache data/tag path. Arbitrates a read requester and a write requester round-robin onto the single SRAM port and registers every SRAM input. Returns read data with a fixed latency. Optionally zero-fills the whole array after reset before accepting any request.

## Interface

Parameters:
- ADDR_WIDTH, 9, SRAM address width (512 entries)
- DATA_WIDTH, 96, data and write-mask width

Ports:
- forever_cpuclk  in  1  clock; the SRAM CLK is driven from the same clock
- cpurst  in  1  reset; one clock, synchronous, active-high
- rd_req  in  1  read request
- rd_addr  in  9  read address
- rd_gnt  out  1  read accepted this cycle
- rd_data_vld  out  1  rd_data valid
- rd_data  out  96  read data, sampled from SRAM Q
- wr_req  in  1  write request
- wr_addr  in  9  write address
- wr_data  in  96  write data
- wr_bmask  in  96  active-high per-bit write enable
- wr_gnt  out  1  write accepted this cycle
- init_busy  out  1  zero-fill sweep in progress
- sram_a  out  9  to SRAM A
- sram_cen  out  1  to SRAM CEN, active-low
- sram_gwen  out  1  to SRAM GWEN; 0 = write
- sram_wen  out  96  to SRAM WEN, active-low = ~mask
- sram_d  out  96  to SRAM D
- sram_q  in  96  from SRAM Q

## Operation

- FSM states: INIT and RUN.
  - Reset enters INIT when CT_L2C_SPSRAM_INIT_EN is defined, otherwise RUN.
- INIT:
  - 9-bit counter runs 0..511, one write per cycle: sram_d=0, all WEN bits enabled.
  - The cycle that issues address 511 transitions the FSM to RUN.
  - rd_gnt and wr_gnt are held 0 throughout INIT.
- RUN:
  - At most one grant per cycle.
  - Grant is combinational from the req inputs and a priority flop. A requester may drop req without being granted.
  - Both requests asserted: grant goes to the requester not granted most recently; priority flop resets to "read wins next".
  - Single request: granted immediately.
  - A grant loads the SRAM input flops:
    - read: cen=0, gwen=1, wen=all 1
    - write: cen=0, gwen=0, wen=~wr_bmask, d=wr_data
  - No grant in a cycle: next cycle cen=1, gwen=1, wen=all 1; a and d hold.
- Ordering:
  - Accesses reach the SRAM in grant order. A read granted after a write to the same address returns the new data; no bypass is needed.
  - A read granted before a write to the same address returns the old data.
- A read-valid pipe (2 flops) tracks outstanding reads. rd_data = sram_q unregistered; it is valid only while rd_data_vld=1.
- Reset at any point, including mid-INIT or with reads in flight:
  - clears all flops; in-flight reads are dropped with no rd_data_vld.
  - with CT_L2C_SPSRAM_INIT_EN defined, the sweep restarts at 0.

## Timing

- Reset values:
  - rd_gnt=0, wr_gnt=0, rd_data_vld=0
  - sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_a=0, sram_d=0
  - init_busy=1 with CT_L2C_SPSRAM_INIT_EN defined, else 0
- Grant in cycle N: SRAM inputs are valid during N+1, and the SRAM captures them at the end of N+1.
- Read granted in cycle N: rd_data_vld=1 and rd_data valid in cycle N+2.
- Throughput: one access per cycle, any mix. Back-to-back reads give back-to-back rd_data_vld.
- Sweep length:
  - first cycle after reset release = cycle 0
  - sweep writes occupy cycles 1..512
  - init_busy falls in cycle 512
  - earliest grant is in cycle 512, the same cycle init_busy falls

## Configuration

- CT_L2C_SPSRAM_INIT_EN defined:
  - INIT state and counter are present.
  - Array is all-zero before the first grant.
- Not defined:
  - No counter; init_busy is tied 0.
  - Requests can be granted in the first cycle after reset release.
  - Array contents are undefined until written.

## Structure

- Shared package ct_l2c_spsram_pkg:
  - ADDR_WIDTH, DATA_WIDTH, ENTRIES (512)
  - FSM state encoding: INIT=1'b0, RUN=1'b1
- Sub-module ct_l2c_spsram_rr_arb:
  - 2-way round-robin arbiter holding the priority flop
  - inputs: req[1:0], en; output: gnt[1:0]
  - en=0 forces gnt=0 (used during INIT)
- Top level instantiates ct_l2c_spsram_rr_arb and ct_spsram_512x96 is external; this block only drives the sram_* ports.

## Test plan

- Init sweep (macro on): after reset release, sram_cen=0 and sram_gwen=0 for exactly 512 cycles, addresses 0..511, sram_d=0. rd_req held high gets no rd_gnt until init_busy falls; it is then granted in that same cycle.
- Write then read:
  - write addr 0x1A5, data 0xDEAD_BEEF_0123_4567_89AB_CDEF, mask all 1
  - next cycle, read addr 0x1A5
  - expect rd_data_vld exactly 2 cycles after rd_gnt, returning that data
- Partial write: wr_bmask=0x0..0_FFFF over a zeroed entry with wr_data all 1. A later read returns 0x0..0_FFFF and sram_wen=~mask.
- Contention: rd_req and wr_req held high for 6 cycles. Expect grants R,W,R,W,R,W, and 3 rd_data_vld pulses each 2 cycles after its grant.
- Reset mid-operation:
  - assert cpurst at sweep address 200 → sweep restarts at 0
  - assert cpurst with 2 reads in flight → no rd_data_vld after reset
- Macro off: rd_req in the first cycle after reset release → rd_gnt the same cycle, init_busy constant 0.
